line_burst_adapter: RTL and testbench

- Responder end of the cache's 256-bit physical-memory line interface (read, write, address, wdata, rdata, resp).
- Sits between the L1 cache datapaths (or their arbiter) and burst main memory.
- Converts each full-line read or write into a fixed-length sequence of 64-bit beats on the memory side.
- Raises a single-cycle line-level response when the line transfer is complete.

---
 rtl/line_adapter_pkg.sv | 19 +
 rtl/line_burst_adapter.sv | 133 +++++++++++++
 tb/tb_line_burst_adapter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_adapter_pkg.sv
// Shared types and sizing helpers for the cache-line to memory-burst adapter.
package line_adapter_pkg;

    localparam int DEFAULT_S_LINE   = 256;
    localparam int DEFAULT_S_BURST  = 64;
    localparam int DEFAULT_S_OFFSET = 5;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } line_adapter_state_t;

    function automatic int beat_count(input int line_w, input int burst_w);
        return line_w / burst_w;
    endfunction

endpackage

// File: rtl/line_burst_adapter.sv
// Splits full-line cache reads/write-backs into fixed-length beat bursts
// toward main memory and returns a one-cycle line-level completion pulse.
module line_burst_adapter
    import line_adapter_pkg::*;
#(
    parameter int s_line    = DEFAULT_S_LINE,
    parameter int s_burst   = DEFAULT_S_BURST,
    parameter int num_beats = beat_count(s_line, s_burst),
    parameter int s_offset  = DEFAULT_S_OFFSET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_read_i,
    input  logic               line_write_i,
    input  logic [31:0]        line_address_i,
    input  logic [s_line-1:0]  line_wdata_i,
    output logic [s_line-1:0]  line_rdata_o,
    output logic               line_resp_o,
    output logic               burst_read_o,
    output logic               burst_write_o,
    output logic [31:0]        burst_address_o,
    output logic [s_burst-1:0] burst_wdata_o,
    input  logic [s_burst-1:0] burst_rdata_i,
    input  logic               burst_resp_i
);

    localparam int cnt_w = $clog2(num_beats);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);
    localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

    line_adapter_state_t state, next_state;
    logic [cnt_w-1:0]  cnt;
    logic [s_line-1:0] wr_line;
    logic [s_line-1:0] rd_line;
    logic [31:0]       addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Write requests win over reads so a dirty eviction precedes its refill.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (line_write_i) begin
                    next_state = WR_BURST;
                end else if (line_read_i) begin
                    next_state = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (burst_resp_i && (cnt == last_beat)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            wr_line <= '0;
            rd_line <= '0;
            addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_write_i || line_read_i) begin
                        addr    <= line_address_i & addr_mask;
                        wr_line <= line_wdata_i;
                        cnt     <= '0;
                    end
                end
                RD_BURST: begin
                    if (burst_resp_i) begin
                        for (int i = 0; i < num_beats; i++) begin
                            if (cnt == cnt_w'(i)) begin
                                rd_line[i*s_burst +: s_burst] <= burst_rdata_i;
                            end
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (burst_resp_i) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes come from flops keyed on next_state so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_read_o  <= 1'b0;
            burst_write_o <= 1'b0;
            line_resp_o   <= 1'b0;
        end else begin
            burst_read_o  <= (next_state == RD_BURST);
            burst_write_o <= (next_state == WR_BURST);
            line_resp_o   <= (next_state == DONE);
        end
    end

    always_comb begin
        burst_wdata_o = '0;
        if (state == WR_BURST) begin
            for (int i = 0; i < num_beats; i++) begin
                if (cnt == cnt_w'(i)) begin
                    burst_wdata_o = wr_line[i*s_burst +: s_burst];
                end
            end
        end
    end

    assign burst_address_o = addr;
    assign line_rdata_o    = rd_line;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench: directed scenarios plus randomized line transfers
// compared against a transaction-level model of the line/burst protocol.
module tb_line_burst_adapter;

    logic         clk;
    logic         rst;
    logic         line_read_i;
    logic         line_write_i;
    logic [31:0]  line_address_i;
    logic [255:0] line_wdata_i;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic         burst_read_o;
    logic         burst_write_o;
    logic [31:0]  burst_address_o;
    logic [63:0]  burst_wdata_o;
    logic [63:0]  burst_rdata_i;
    logic         burst_resp_i;

    int total;
    int bad;
    logic [255:0] exp_rdata;

    line_burst_adapter dut (
        .clk             (clk),
        .rst             (rst),
        .line_read_i     (line_read_i),
        .line_write_i    (line_write_i),
        .line_address_i  (line_address_i),
        .line_wdata_i    (line_wdata_i),
        .line_rdata_o    (line_rdata_o),
        .line_resp_o     (line_resp_o),
        .burst_read_o    (burst_read_o),
        .burst_write_o   (burst_write_o),
        .burst_address_o (burst_address_o),
        .burst_wdata_o   (burst_wdata_o),
        .burst_rdata_i   (burst_rdata_i),
        .burst_resp_i    (burst_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One line transfer, starting and ending at a negedge in IDLE.
    // Memory responses come from resp_mask (bit n = cycle n) or from wait_pct.
    task automatic applyStimulus(input bit is_wr, input bit also_rd, input logic [31:0] addr,
                                 input logic [255:0] wdata, input int wait_pct,
                                 input bit use_mask, input logic [31:0] resp_mask,
                                 input bit scramble);
        logic [255:0] line;
        logic [63:0]  beat;
        int k;
        int cycles;
        int waits;
        bit resp;
        line_address_i = addr;
        line_wdata_i   = wdata;
        line_write_i   = is_wr;
        line_read_i    = !is_wr || also_rd;
        burst_resp_i   = 1'b0;
        @(negedge clk);
        line = exp_rdata;
        k = 0;
        cycles = 0;
        waits = 0;
        while (k < 4 && cycles < 40) begin
            checkOutput("burst_read", 256'(burst_read_o), 256'(!is_wr));
            checkOutput("burst_write", 256'(burst_write_o), 256'(is_wr));
            checkOutput("burst_addr", 256'(burst_address_o), 256'(addr & 32'hFFFF_FFE0));
            checkOutput("resp_early", 256'(line_resp_o), 256'(0));
            checkOutput("rdata_mid", line_rdata_o, line);
            if (is_wr) checkOutput("wdata", 256'(burst_wdata_o), 256'(wdata[k*64 +: 64]));
            if (scramble) begin
                line_address_i = $urandom;
                line_wdata_i   = rand256();
            end
            if (use_mask) resp = (cycles < 32) ? resp_mask[cycles] : 1'b1;
            else resp = !(waits < 3 && $urandom_range(99) < wait_pct);
            beat = {$urandom, $urandom};
            burst_rdata_i = beat;
            burst_resp_i  = resp;
            if (resp) begin
                if (!is_wr) line[k*64 +: 64] = beat;
                k++;
                waits = 0;
            end else begin
                waits++;
            end
            cycles++;
            @(negedge clk);
        end
        checkOutput("beats_taken", 256'(k), 256'(4));
        burst_resp_i = 1'b0;
        if (!is_wr) exp_rdata = line;
        checkOutput("resp_pulse", 256'(line_resp_o), 256'(1));
        checkOutput("done_read", 256'(burst_read_o), 256'(0));
        checkOutput("done_write", 256'(burst_write_o), 256'(0));
        checkOutput("done_rdata", line_rdata_o, exp_rdata);
        line_write_i = 1'b0;
        line_read_i  = is_wr && also_rd;
        @(negedge clk);
        checkOutput("resp_single", 256'(line_resp_o), 256'(0));
        checkOutput("idle_read", 256'(burst_read_o), 256'(0));
        checkOutput("idle_write", 256'(burst_write_o), 256'(0));
    endtask

    initial begin
        logic [255:0] wd;
        logic [63:0]  b;
        total = 0;
        bad = 0;
        exp_rdata = '0;
        rst = 1'b1;
        line_read_i = 1'b0;
        line_write_i = 1'b0;
        line_address_i = '0;
        line_wdata_i = '0;
        burst_rdata_i = '0;
        burst_resp_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_read", 256'(burst_read_o), 256'(0));
        checkOutput("rst_write", 256'(burst_write_o), 256'(0));
        checkOutput("rst_resp", 256'(line_resp_o), 256'(0));
        checkOutput("rst_addr", 256'(burst_address_o), 256'(0));
        checkOutput("rst_wdata", 256'(burst_wdata_o), 256'(0));
        checkOutput("rst_rdata", line_rdata_o, 256'(0));
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] read, no gaps");
        line_address_i = 32'h0000_1234;
        line_read_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checkOutput("nogap_addr", 256'(burst_address_o), 256'(32'h0000_1220));
            checkOutput("nogap_resp_early", 256'(line_resp_o), 256'(0));
            b = {16{4'(i + 1)}};
            burst_rdata_i = b;
            burst_resp_i = 1'b1;
            @(negedge clk);
        end
        burst_resp_i = 1'b0;
        exp_rdata = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        checkOutput("nogap_resp_t5", 256'(line_resp_o), 256'(1));
        checkOutput("nogap_rdata", line_rdata_o, exp_rdata);
        line_read_i = 1'b0;
        @(negedge clk);
        checkOutput("nogap_resp_single", 256'(line_resp_o), 256'(0));

        $display("[TB] write with wait states");
        wd = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
        applyStimulus(1'b1, 1'b0, 32'h1000_00FF, wd, 0, 1'b1, 32'b1100101, 1'b1);

        $display("[TB] simultaneous read and write");
        applyStimulus(1'b1, 1'b1, 32'h8000_0040, rand256(), 30, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h8000_0040, rand256(), 30, 1'b0, 32'd0, 1'b0);

        $display("[TB] reset mid-read");
        line_address_i = 32'h0000_2000;
        line_read_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            burst_rdata_i = {$urandom, $urandom};
            burst_resp_i = 1'b1;
            @(negedge clk);
        end
        burst_resp_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_read", 256'(burst_read_o), 256'(0));
        checkOutput("arst_write", 256'(burst_write_o), 256'(0));
        checkOutput("arst_resp", 256'(line_resp_o), 256'(0));
        checkOutput("arst_addr", 256'(burst_address_o), 256'(0));
        checkOutput("arst_rdata", line_rdata_o, 256'(0));
        line_read_i = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_resp", 256'(line_resp_o), 256'(0));
        checkOutput("post_rst_read", 256'(burst_read_o), 256'(0));
        applyStimulus(1'b0, 1'b0, 32'h0000_2010, '0, 20, 1'b0, 32'd0, 1'b0);

        $display("[TB] spurious resp in idle");
        for (int i = 0; i < 3; i++) begin
            burst_resp_i = 1'b1;
            burst_rdata_i = {$urandom, $urandom};
            @(negedge clk);
            checkOutput("spur_read", 256'(burst_read_o), 256'(0));
            checkOutput("spur_resp", 256'(line_resp_o), 256'(0));
            checkOutput("spur_rdata", line_rdata_o, exp_rdata);
        end
        burst_resp_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'hCAFE_0007, '0, 0, 1'b0, 32'd0, 1'b0);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 24; n++) begin
            applyStimulus(1'($urandom_range(1)), 1'b0, $urandom, rand256(),
                          $urandom_range(60), 1'b0, 32'd0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
